shift_issue_stage: RTL and testbench

Operand-capture and issue buffer that sits directly upstream of the 32-bit barrel shifters (sll/sra) in the ALU shift path. It accepts shift requests through a valid/ready handshake, queues them in a small FIFO, tags each one in order, and presents the head request as registered operand and control signals to the shifter. The shifter itself stays purely combinational; this block supplies all of the sequencing.

---
 rtl/shift_issue_stage.sv | 160 ++++++++++++++++
 tb/tb_shift_issue_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - operand-capture and issue FIFO feeding the 32-bit sll/sra barrel shifter
//
// Purpose:
//   Accepts shift requests over a valid/ready handshake, queues them in a
//   DEPTH-entry FIFO, stamps each with an in-order tag and presents the head
//   entry as registered operand/control signals to a purely combinational
//   shifter. No fall-through: an accepted request shows at the head one
//   cycle later.
//
// Optional feature (macro SHIFT_ISSUE_STATS_EN):
//   Adds stat_stall_cycles (saturating count of in_valid && !in_ready cycles)
//   and stat_issued (wrapping count of pops).
//
// Ports:
//   clock, reset_n     clock and asynchronous active-low reset
//   in_valid/in_ready  upstream handshake; in_ready is registered
//   in_operandA        value to shift
//   in_shiftamt        shift amount 0..31
//   in_sra             0 = logical left, 1 = arithmetic right
//   out_valid/out_ready downstream handshake for the head entry
//   data_operandA, ctrl_shiftamt, ctrl_sra, out_tag
//                      head entry fields, zero while empty
//   occupancy          number of queued entries
//   stat_stall_cycles, stat_issued  (SHIFT_ISSUE_STATS_EN only)

module shift_issue_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_operandA,
    input  logic [4:0]               in_shiftamt,
    input  logic                     in_sra,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              data_operandA,
    output logic [4:0]               ctrl_shiftamt,
    output logic                     ctrl_sra,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    output logic [15:0]              stat_stall_cycles,
    output logic [15:0]              stat_issued
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]      operand;
        logic [4:0]       shamt;
        logic             sra;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [TAG_W-1:0]   r_tag_cnt;
    logic               r_in_ready;

    logic               w_not_empty;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_next;
    entry_t             w_head;

    // ------------------------------------------------------------------
    // Handshake decode. in_ready is a register, so the push decision
    // never depends on out_ready in the same cycle.
    // ------------------------------------------------------------------
    assign w_not_empty  = (r_count != '0);
    assign w_push       = in_valid && r_in_ready;
    assign w_pop        = w_not_empty && out_ready;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // ------------------------------------------------------------------
    // Control state: pointers, count, tag counter, registered in_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tag_cnt  <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                r_tag_cnt <= r_tag_cnt + TAG_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_next;
            // Looks ahead at the post-update count so a pop while full
            // reopens the input exactly one cycle later.
            r_in_ready <= (w_count_next < DEPTH_C);
        end
    end

    // Storage needs no reset: every read is gated by the entry count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{operand: in_operandA,
                                 shamt:   in_shiftamt,
                                 sra:     in_sra,
                                 tag:     r_tag_cnt};
        end
    end

    // ------------------------------------------------------------------
    // Head presentation: driven only from registers, forced to zero when
    // empty so the shifter sees a quiet bus.
    // ------------------------------------------------------------------
    always_comb begin
        w_head = '0;
        if (w_not_empty) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = w_not_empty;
    assign data_operandA = w_head.operand;
    assign ctrl_shiftamt = w_head.shamt;
    assign ctrl_sra      = w_head.sra;
    assign out_tag       = w_head.tag;
    assign occupancy     = r_count;

`ifdef SHIFT_ISSUE_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_issued;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_issued       <= '0;
        end else begin
            if (in_valid && !r_in_ready && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_pop) begin
                r_issued <= r_issued + 16'd1;
            end
        end
    end

    assign stat_stall_cycles = r_stall_cycles;
    assign stat_issued       = r_issued;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - scoreboard bench for shift_issue_stage
module tb_shift_issue_stage;

    localparam int DEPTH = 2;
    localparam int TAG_W = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_operandA = '0;
    logic [4:0]  in_shiftamt = '0;
    logic        in_sra = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic        ctrl_sra;
    logic [TAG_W-1:0] out_tag;
    logic [$clog2(DEPTH):0] occupancy;
`ifdef SHIFT_ISSUE_STATS_EN
    logic [15:0] stat_stall_cycles;
    logic [15:0] stat_issued;
`endif

    shift_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_operandA   (in_operandA),
        .in_shiftamt   (in_shiftamt),
        .in_sra        (in_sra),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_operandA (data_operandA),
        .ctrl_shiftamt (ctrl_shiftamt),
        .ctrl_sra      (ctrl_sra),
        .out_tag       (out_tag),
        .occupancy     (occupancy)
`ifdef SHIFT_ISSUE_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_issued       (stat_issued)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  s;
        logic        r;
        logic [3:0]  t;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    ent_t exp_q[$];
    int   popped_tags[$];

    int m_count    = 0;
    bit m_in_ready = 1'b0;
    int m_tag      = 0;
    bit m_acc      = 1'b0;
    int m_stall    = 0;
    int m_issued   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] s, input logic r);
        in_valid    = v;
        in_operandA = a;
        in_shiftamt = s;
        in_sra      = r;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: a request queue plus an entry count.
    always @(posedge clock or negedge reset_n) begin
        bit push;
        bit pop;
        if (!reset_n) begin
            m_count = 0; m_in_ready = 1'b0; m_tag = 0; m_acc = 1'b0;
            m_stall = 0; m_issued = 0;
            exp_q.delete();
        end else begin
            push = in_valid && m_in_ready;
            pop  = (m_count > 0) && out_ready;
            if (in_valid && !m_in_ready && m_stall < 65535) m_stall++;
            if (pop) m_issued = (m_issued + 1) % 65536;
            if (push) begin
                exp_q.push_back({in_operandA, in_shiftamt, in_sra, 4'(m_tag)});
                m_tag = (m_tag + 1) % 16;
            end
            m_acc      = push;
            m_count    = m_count + int'(push) - int'(pop);
            m_in_ready = (m_count < DEPTH);
        end
    end

    // Monitor: compares on the falling edge, pops the scoreboard on a consume.
    always @(negedge clock) begin
        ent_t e;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
        chk("occupancy", 32'(occupancy), 32'(m_count));
        chk("out_valid", {31'd0, out_valid}, {31'd0, (m_count != 0)});
        if (!out_valid) begin
            chk("idle_data", data_operandA, 32'd0);
            chk("idle_ctrl", {22'd0, ctrl_shiftamt, ctrl_sra, out_tag}, 32'd0);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=out_valid expected=empty");
        end else begin
            e = exp_q[0];
            chk("head_data", data_operandA, e.a);
            chk("head_shamt", 32'(ctrl_shiftamt), 32'(e.s));
            chk("head_sra", 32'(ctrl_sra), 32'(e.r));
            chk("head_tag", 32'(out_tag), 32'(e.t));
            if (out_ready) begin
                popped_tags.push_back(int'(e.t));
                void'(exp_q.pop_front());
            end
        end
`ifdef SHIFT_ISSUE_STATS_EN
        chk("stat_stall", 32'(stat_stall_cycles), 32'(m_stall));
        chk("stat_issued", 32'(stat_issued), 32'(m_issued));
`endif
    end

    initial begin
        // Reset and idle
        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);

        // Single request
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0001, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("single_data", data_operandA, 32'h8000_0001);
        chk("single_shamt", 32'(ctrl_shiftamt), 32'd4);
        chk("single_sra", 32'(ctrl_sra), 32'd1);
        chk("single_tag", 32'(out_tag), 32'd0);
        chk("single_occ", 32'(occupancy), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill and backpressure: third request must stall
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 5'($urandom), 1'($urandom));
            tick();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd2);
        chk("full_head_tag", 32'(out_tag), 32'd1);
        repeat (4) tick();
`ifdef SHIFT_ISSUE_STATS_EN
        chk("stall_five", 32'(stat_stall_cycles), 32'd5);
`endif

        // Drain while full
        popped_tags.delete();
        out_ready = 1'b1;
        tick();
        chk("reopen_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("drain_count", 32'(popped_tags.size()), 32'd3);
        for (int i = 0; i < popped_tags.size() && i < 3; i++)
            chk("drain_tag", 32'(popped_tags[i]), 32'(i + 1));

        // Fill to two, then a short mid-operation reset
        out_ready = 1'b0;
        drive(1'b1, $urandom, 5'($urandom), 1'($urandom));
        tick();
        drive(1'b1, $urandom, 5'($urandom), 1'($urandom));
        tick();
        in_valid = 1'b0;
        chk("pre_reset_occ", 32'(occupancy), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_tag", 32'(out_tag), 32'd0);
        #2 reset_n = 1'b1;
        tick();

        // Tag wrap: 17 back-to-back requests
        popped_tags.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, $urandom, 5'($urandom), 1'($urandom));
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("wrap_count", 32'(popped_tags.size()), 32'd17);
        for (int i = 0; i < popped_tags.size() && i < 17; i++)
            chk("wrap_tag", 32'(popped_tags[i]), 32'(i % 16));

        // Randomized traffic with random backpressure
        for (int c = 0; c < 2000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || m_acc)
                drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 1'($urandom));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
